// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store initiator for a word-wide single-cycle data memory.
// Byte and half stores are done as read-modify-write. Sub-word loads are
// extracted from the addressed lane, then sign- or zero-extended.
// Each request gets exactly one response. Illegal accesses are flagged
// with resp_err and never touch memory.
// Optional feature macro: DMEM_LSU_STATS_EN adds saturating 16-bit
// load/store/error counters.
module dmem_lsu #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
`ifdef DMEM_LSU_STATS_EN
  ,
  output logic [15:0] stat_loads,
  output logic [15:0] stat_stores,
  output logic [15:0] stat_errs
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_t;

  state_t      state_r;
  state_t      state_s;

  logic        we_r;
  logic [1:0]  size_r;
  logic        sgn_r;
  logic [1:0]  lane_r;
  logic [31:0] wdata_r;
  logic        err_r;

  logic [31:0] mem_addr_r;
  logic [31:0] mem_wd_r;
  logic [31:0] resp_rdata_r;
  logic        resp_err_r;

  logic        accept_s;
  logic        req_err_s;

  // Alignment, size and range check on the incoming request.
  function automatic logic access_illegal(input logic [1:0] size,
                                          input logic [31:0] addr);
    logic bad;
    bad = 1'b0;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr[0];
      2'b10:   bad = (addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
    if ({2'b00, addr[31:2]} >= 32'(MEM_WORDS)) begin
      bad = 1'b1;
    end
    return bad;
  endfunction

  // Pick the addressed lane out of a memory word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  size,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      2'b10:   r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Overlay right-justified store data onto the addressed lane of a word.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wd,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00: r[{lane, 3'b000} +: 8] = wd[7:0];
      2'b01: begin
        if (lane[1]) begin
          r[31:16] = wd[15:0];
        end else begin
          r[15:0] = wd[15:0];
        end
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  assign accept_s   = req_valid & (state_r == IDLE);
  assign req_err_s  = access_illegal(req_size, req_addr);

  // State-decoded handshakes: a reset drops mem_we at once.
  assign req_ready  = (state_r == IDLE);
  assign resp_valid = (state_r == RESP);
  assign mem_we     = (state_r == WR);
  assign mem_addr   = mem_addr_r;
  assign mem_wd     = mem_wd_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

  // Next-state decode for the request sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (req_err_s) begin
            state_s = RESP;
          end else if (!req_we || (req_size != 2'b10)) begin
            state_s = RD;
          end else begin
            state_s = WR;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD: begin
        if (we_r) begin
          state_s = WR;
        end else begin
          state_s = RESP;
        end
      end
      WR:      state_s = RESP;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Latch request fields on accept so later input changes are ignored.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_r    <= 1'b0;
      size_r  <= 2'b00;
      sgn_r   <= 1'b0;
      lane_r  <= 2'b00;
      wdata_r <= 32'h0000_0000;
      err_r   <= 1'b0;
    end else if (accept_s) begin
      we_r    <= req_we;
      size_r  <= req_size;
      sgn_r   <= req_signed;
      lane_r  <= req_addr[1:0];
      wdata_r <= req_wdata;
      err_r   <= req_err_s;
    end
  end

  // Memory address: set only by legal accesses, held while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr_r <= 32'h0000_0000;
    end else if (accept_s && !req_err_s) begin
      mem_addr_r <= {req_addr[31:2], 2'b00};
    end
  end

  // Write word: direct for word stores, read-modify-write merge otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_wd_r <= 32'h0000_0000;
    end else if (accept_s && !req_err_s && req_we && (req_size == 2'b10)) begin
      mem_wd_r <= req_wdata;
    end else if ((state_r == RD) && we_r) begin
      mem_wd_r <= store_merge(mem_rd, wdata_r, lane_r, size_r);
    end
  end

  // Response data/error, updated on the edge that enters RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_rdata_r <= 32'h0000_0000;
      resp_err_r   <= 1'b0;
    end else if ((state_r == RD) && !we_r) begin
      resp_rdata_r <= load_extract(mem_rd, lane_r, size_r, sgn_r);
      resp_err_r   <= 1'b0;
    end else if (state_r == WR) begin
      resp_rdata_r <= 32'h0000_0000;
      resp_err_r   <= 1'b0;
    end else if (accept_s && req_err_s) begin
      resp_rdata_r <= 32'h0000_0000;
      resp_err_r   <= 1'b1;
    end
  end

`ifdef DMEM_LSU_STATS_EN
  // Saturating per-class counters, bumped once per response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_loads  <= 16'h0000;
      stat_stores <= 16'h0000;
      stat_errs   <= 16'h0000;
    end else if (state_r == RESP) begin
      if (err_r) begin
        if (stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'h0001;
      end else if (we_r) begin
        if (stat_stores != 16'hFFFF) stat_stores <= stat_stores + 16'h0001;
      end else begin
        if (stat_loads != 16'hFFFF) stat_loads <= stat_loads + 16'h0001;
      end
    end
  end
`endif

endmodule
